// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The frame is CNT_HI CNT_LO {DAT_HI DAT_LO}*N CHK.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_CNT_HI = 3'd0,
        S_CNT_LO = 3'd1,
        S_DAT_HI = 3'd2,
        S_DAT_LO = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } t_ldr_state;

    localparam int FRAME_HDR_BYTES = 2;
    localparam int CHK_WIDTH       = 8;

    // True in every state that is still consuming frame bytes.
    function automatic logic is_loading(input t_ldr_state s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DAT_HI) ||
               (s == S_DAT_LO) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Receives a framed program image over a byte stream, writes it into the
// instruction ROM and holds the CPU in reset until a good checksum is seen.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ROM_DEPTH   = 1024,
    parameter int ADDR_W      = $clog2(ROM_DEPTH),
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   load_req,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   rom_we,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [INSTR_WIDTH-1:0] rom_wdata,
    output logic                   cpu_resetN,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam logic [16:0] MAX_WORDS = 17'(ROM_DEPTH);

    // Handshake: a byte moves on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    t_ldr_state           state;
    t_ldr_state           state_nxt;
    logic [15:0]          word_left;
    logic [ADDR_W-1:0]    word_addr;
    logic [7:0]           hi_byte;
    logic [CHK_WIDTH-1:0] chk_acc;

    logic        xfer;
    logic        load_accept;
    logic [15:0] word_count;
    logic        len_bad;
    logic        chk_ok;

    assign in_ready    = is_loading(state);
    assign busy        = is_loading(state);
    assign cpu_resetN  = (state == S_DONE);
    assign xfer        = in_valid && in_ready;
    assign load_accept = load_req && ((state == S_DONE) || (state == S_ERR));
    assign word_count  = {hi_byte, in_data};
    assign len_bad     = {1'b0, word_count} > MAX_WORDS;
    assign chk_ok      = (in_data == chk_acc);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= S_CNT_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CNT_HI: if (xfer) state_nxt = S_CNT_LO;
            S_CNT_LO: begin
                if (xfer) begin
                    if (len_bad)                 state_nxt = S_ERR;
                    else if (word_count == 16'd0) state_nxt = S_CHK;
                    else                         state_nxt = S_DAT_HI;
                end
            end
            S_DAT_HI: if (xfer) state_nxt = S_DAT_LO;
            S_DAT_LO: begin
                if (xfer) state_nxt = (word_left == 16'd1) ? S_CHK : S_DAT_HI;
            end
            S_CHK:    if (xfer) state_nxt = chk_ok ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:    if (load_accept) state_nxt = S_CNT_HI;
            default:  state_nxt = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            word_left <= '0;
            word_addr <= '0;
            hi_byte   <= '0;
            chk_acc   <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            if (load_accept) begin
                done      <= 1'b0;
                error     <= 1'b0;
                word_addr <= '0;
                chk_acc   <= '0;
            end else if (xfer) begin
                // The accumulator always holds the sum of bytes before the current one.
                chk_acc <= chk_acc + in_data;
                case (state)
                    S_CNT_HI: hi_byte <= in_data;
                    S_CNT_LO: begin
                        word_left <= word_count;
                        if (len_bad) error <= 1'b1;
                    end
                    S_DAT_HI: hi_byte <= in_data;
                    S_DAT_LO: begin
                        rom_we    <= 1'b1;
                        rom_addr  <= word_addr;
                        rom_wdata <= {hi_byte, in_data};
                        word_addr <= word_addr + 1'b1;
                        word_left <= word_left - 16'd1;
                    end
                    S_CHK: begin
                        if (chk_ok) done  <= 1'b1;
                        else        error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed checksums,
// write scoreboard, length/checksum errors, reset mid-load and reload.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W = 10;
    localparam int W      = ADDR_W + 16;

    logic              clk;
    logic              resetN;
    logic              load_req;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_resetN;
    logic              busy;
    logic              done;
    logic              error;

    int tests;
    int fails;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [7:0]   byte_q[$];

    prog_loader #(.ROM_DEPTH(1024)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .load_req   (load_req),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .cpu_resetN (cpu_resetN),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rom_we) got_q.push_back({rom_addr, rom_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        resetN   = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int gap);
        foreach (byte_q[i]) send_byte(byte_q[i], gap);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        logic [W-1:0] g;
        logic [W-1:0] e;
        check({tag, "_we_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_write"}, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        resetN   = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (2) @(negedge clk);

        // reset values, with a byte offered that must not be consumed
        check("rst_state", 32'(dut.state), 32'(S_CNT_HI));
        check("rst_rom_we", {31'd0, rom_we}, 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_wdata", 32'(rom_wdata), 32'd0);
        check("rst_cpu_resetN", {31'd0, cpu_resetN}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        do_reset();

        // good two-word frame, byte-by-byte timing checks
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        check("w0_we", {31'd0, rom_we}, 32'd1);
        check("w0_addr", 32'(rom_addr), 32'd0);
        check("w0_data", 32'(rom_wdata), 32'hABCD);
        send_byte(8'h12, 0);
        check("w0_pulse_end", {31'd0, rom_we}, 32'd0);
        send_byte(8'h34, 0);
        load_req = 1'b1;
        send_byte(8'hC0, 0);
        load_req = 1'b0;
        in_valid = 1'b0;
        check("ok_done", {31'd0, done}, 32'd1);
        check("ok_cpu_resetN", {31'd0, cpu_resetN}, 32'd1);
        check("ok_in_ready", {31'd0, in_ready}, 32'd0);
        check("ok_busy", {31'd0, busy}, 32'd0);
        check("ok_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        check("ok_state_held", 32'(dut.state), 32'(S_DONE));
        exp_q.push_back({10'd0, 16'hABCD});
        exp_q.push_back({10'd1, 16'h1234});
        check_writes("ok");

        // bad checksum
        do_reset();
        byte_q = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'hC1};
        send_frame(0);
        check("bad_error", {31'd0, error}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_cpu_resetN", {31'd0, cpu_resetN}, 32'd0);
        check("bad_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.push_back({10'd0, 16'hABCD});
        exp_q.push_back({10'd1, 16'h1234});
        check_writes("bad");

        // word count 1025 exceeds the ROM
        do_reset();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        check("len_state", 32'(dut.state), 32'(S_ERR));
        check("len_in_ready", {31'd0, in_ready}, 32'd0);
        check("len_error", {31'd0, error}, 32'd1);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check_writes("len");

        // empty program
        do_reset();
        byte_q = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_cpu_resetN", {31'd0, cpu_resetN}, 32'd1);
        check_writes("empty");

        // gaps of three idle cycles between bytes
        do_reset();
        byte_q = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'hC0};
        send_frame(3);
        check("gap_done", {31'd0, done}, 32'd1);
        check("gap_error", {31'd0, error}, 32'd0);
        exp_q.push_back({10'd0, 16'hABCD});
        exp_q.push_back({10'd1, 16'h1234});
        check_writes("gap");

        // reset asserted on the edge that would accept the 4th byte
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAB, 0);
        in_data = 8'hCD;
        resetN  = 1'b0;
        @(negedge clk);
        check("mid_rst_we", {31'd0, rom_we}, 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(S_CNT_HI));
        in_valid = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        check_writes("mid_rst");
        byte_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
        send_frame(0);
        check("mid_rst_reload_done", {31'd0, done}, 32'd1);
        exp_q.push_back({10'd0, 16'h1234});
        check_writes("mid_rst_reload");

        // reload request from S_DONE
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("req_done", {31'd0, done}, 32'd0);
        check("req_cpu_resetN", {31'd0, cpu_resetN}, 32'd0);
        check("req_in_ready", {31'd0, in_ready}, 32'd1);
        byte_q = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF};
        send_frame(0);
        check("req_load_done", {31'd0, done}, 32'd1);
        check("req_load_cpu_resetN", {31'd0, cpu_resetN}, 32'd1);
        exp_q.push_back({10'd0, 16'hFFFF});
        check_writes("req");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
